stp_window: RTL

- Parametrised serial-to-parallel windowing block; the next generation of the 16x16 fixed STP.
- Collects `DEPTH` signed samples from the FIR output stream into a parallel frame for the downstream transform stage.
- Adds overlapping windows (hop size `HOP`), a held output snapshot, a synchronous restart and a frame counter.
- Sits between the FIR filter (`fir_valid`/`fir_d`) and the block consuming parallel frames.

---
 rtl/stp_window.sv | 87 ++++++++
 1 files changed

// File: rtl/stp_window.sv
// Serial-to-parallel windowing: collects DEPTH signed samples into a held
// parallel frame, emitting overlapping windows every HOP accepted samples.
module stp_window #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int HOP    = 16,
  parameter int FCNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    fir_valid,
  input  logic [DATA_W-1:0]       fir_d,
  output logic                    stp_valid,
  output logic [DEPTH*DATA_W-1:0] stp_data,
  output logic [FCNT_W-1:0]       frame_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int FW    = DEPTH * DATA_W;

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] HOP_LAST  = CNT_W'(HOP - 1);

  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("stp_window: DEPTH must be in 2..64");
  end

  if (HOP < 1 || HOP > DEPTH) begin : g_bad_hop
    $error("stp_window: HOP must be in 1..DEPTH");
  end

  logic [FW-1:0]     r_chain;
  logic [FW-1:0]     r_frame;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_primed;
  logic              r_valid;
  logic [FCNT_W-1:0] r_fcnt;

  logic [FW-1:0] w_shift;
  logic          w_acc;
  logic          w_last;
  logic          w_evt;

  // Oldest sample lives in slice 0; the new sample enters the top slice.
  assign w_shift = {fir_d, r_chain[FW-1:DATA_W]};
  assign w_acc   = fir_valid & ~clr;
  assign w_last  = r_primed ? (r_cnt == HOP_LAST)
                            : (r_cnt == FILL_LAST);
  assign w_evt   = w_acc & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain  <= '0;
      r_frame  <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_fcnt   <= '0;
    end else if (clr) begin
      r_chain  <= '0;
      r_frame  <= '0;
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_valid <= w_evt;
      if (w_acc) begin
        r_chain <= w_shift;
        if (w_last) begin
          r_cnt    <= '0;
          r_primed <= 1'b1;
          r_frame  <= w_shift;
          r_fcnt   <= r_fcnt + FCNT_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign stp_valid = r_valid;
  assign stp_data  = r_frame;
  assign frame_cnt = r_fcnt;

endmodule
